// File: rtl/requant_pipe.sv
// ---------------------------------------------------------------------------
// requant_pipe
//
// Three-stage requantization pipeline. It turns a signed wide accumulator into
// a signed 8-bit activation using a per-channel unsigned scale, a power-of-two
// right shift with optional round-half-up, an output zero point and a clamp
// (with optional ReLU lower bound). Clamped results are counted.
//
// Stages:
//   S1  registers acc and the looked-up channel scale
//   S2  registers the full-width signed product
//   S3  rounds, shifts, adds the zero point, clamps and registers q_o
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   in_valid_i / in_ready_o   input beat handshake
//   acc_i, ch_i               signed accumulator and its channel index
//   out_valid_o / out_ready_i output beat handshake
//   q_o                       signed 8-bit result
//   cfg_we_i, cfg_addr_i,
//   cfg_scale_i               scale table write port
//   zero_point_i, round_en_i,
//   relu_en_i                 quasi-static arithmetic controls
//   sat_cnt_o, sat_clr_i      saturation counter and its synchronous clear
// ---------------------------------------------------------------------------
module requant_pipe #(
  parameter  int ACC_W   = 24,
  parameter  int SCALE_W = 16,
  parameter  int SHIFT   = 22,
  parameter  int NUM_CH  = 64,
  parameter  int CNT_W   = 16,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic signed [ACC_W-1:0]   acc_i,
  input  logic        [CH_W-1:0]    ch_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic signed [7:0]         q_o,
  input  logic                      cfg_we_i,
  input  logic        [CH_W-1:0]    cfg_addr_i,
  input  logic        [SCALE_W-1:0] cfg_scale_i,
  input  logic signed [7:0]         zero_point_i,
  input  logic                      round_en_i,
  input  logic                      relu_en_i,
  output logic        [CNT_W-1:0]   sat_cnt_o,
  input  logic                      sat_clr_i
);

  // Product width: signed acc times zero-extended scale. RW adds the rounding
  // guard bit, VW leaves headroom for the zero-point addition.
  localparam int PW = ACC_W + SCALE_W + 1;
  localparam int RW = PW + 1;
  localparam int VW = PW + 2;

  localparam logic [SCALE_W-1:0]    SCALE_RST = {1'b1, {(SCALE_W-1){1'b0}}};
  localparam logic [RW-1:0]         RND_HALF  = RW'(1) << (SHIFT - 1);
  localparam logic signed [VW-1:0]  Q_MAX     = VW'(127);
  localparam logic signed [VW-1:0]  Q_MIN     = VW'(-128);

  // State registers and their next-state values
  logic                      readyEn_q;
  logic                      s1Valid_q, s1Valid_d;
  logic signed [ACC_W-1:0]   s1Acc_q, s1Acc_d;
  logic        [SCALE_W-1:0] s1Scale_q, s1Scale_d;
  logic                      s2Valid_q, s2Valid_d;
  logic signed [PW-1:0]      s2Prod_q, s2Prod_d;
  logic                      outValid_q, outValid_d;
  logic signed [7:0]         q_q, q_d;
  logic        [CNT_W-1:0]   satCnt_q, satCnt_d;
  logic        [SCALE_W-1:0] scaleTab_q [NUM_CH];

  // Handshake and datapath intermediates
  logic                      outLoad, s2Load, s1Load, inFire;
  logic                      chInRange, addrInRange;
  logic        [SCALE_W-1:0] chScale;
  logic signed [PW-1:0]      accExt, scaleExt, product;
  logic signed [RW-1:0]      prodRnd, shifted;
  logic signed [VW-1:0]      zpExt, vVal, lowBound;
  logic                      satEvent;
  logic signed [7:0]         clampQ;

  // The scale table holds one factor per channel. A write lands on the clock
  // edge, so a beat accepted in the same cycle still reads the old entry.
  // Writes to addresses beyond the table are dropped.
  assign addrInRange = int'(cfg_addr_i) < NUM_CH;
  assign chInRange   = int'(ch_i) < NUM_CH;
  assign chScale     = chInRange ? scaleTab_q[ch_i] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CH; i++) begin
        scaleTab_q[i] <= SCALE_RST;
      end
    end else if (cfg_we_i && addrInRange) begin
      scaleTab_q[cfg_addr_i] <= cfg_scale_i;
    end
  end

  // Each stage may load when it is empty or its successor is loading. This
  // lets bubbles collapse even while the output register is stalled.
  // readyEn_q keeps the input closed until the first edge after reset.
  assign outLoad    = !outValid_q || out_ready_i;
  assign s2Load     = !s2Valid_q || outLoad;
  assign s1Load     = !s1Valid_q || s2Load;
  assign in_ready_o = readyEn_q && s1Load;
  assign inFire     = in_valid_i && in_ready_o;

  // S2 arithmetic: both operands widened to the product width so the
  // multiply is exact; the scale is treated as unsigned.
  assign accExt   = {{(PW-ACC_W){s1Acc_q[ACC_W-1]}}, s1Acc_q};
  assign scaleExt = {{(PW-SCALE_W){1'b0}}, s1Scale_q};
  assign product  = accExt * scaleExt;

  // S3 arithmetic: the extra guard bit absorbs the rounding increment, then
  // an arithmetic shift gives floor semantics for negative values.
  assign prodRnd  = {s2Prod_q[PW-1], s2Prod_q} + (round_en_i ? RND_HALF : '0);
  assign shifted  = prodRnd >>> SHIFT;
  assign zpExt    = {{(VW-8){zero_point_i[7]}}, zero_point_i};
  assign vVal     = {{(VW-RW){shifted[RW-1]}}, shifted} + zpExt;
  assign lowBound = relu_en_i ? zpExt : Q_MIN;

  // Saturation is judged against the fixed int8 range, so a ReLU clamp to the
  // zero point alone never counts as an event.
  assign satEvent = (vVal > Q_MAX) || (vVal < Q_MIN);
  assign clampQ   = (vVal < lowBound) ? lowBound[7:0] :
                    (vVal > Q_MAX)    ? 8'sd127       : vVal[7:0];

  // Next-state logic for the three stages and the saturation counter. Data
  // registers only change when a valid beat moves into them, which keeps q_o
  // stable while the output is stalled.
  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1Acc_d    = s1Acc_q;
    s1Scale_d  = s1Scale_q;
    s2Valid_d  = s2Valid_q;
    s2Prod_d   = s2Prod_q;
    outValid_d = outValid_q;
    q_d        = q_q;
    satCnt_d   = satCnt_q;

    if (s1Load) begin
      s1Valid_d = inFire;
      if (inFire) begin
        s1Acc_d   = acc_i;
        s1Scale_d = chScale;
      end
    end

    if (s2Load) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) begin
        s2Prod_d = product;
      end
    end

    if (outLoad) begin
      outValid_d = s2Valid_q;
      if (s2Valid_q) begin
        q_d = clampQ;
      end
    end

    if (sat_clr_i) begin
      satCnt_d = '0;
    end else if (outLoad && s2Valid_q && satEvent && (satCnt_q != '1)) begin
      satCnt_d = satCnt_q + CNT_W'(1);
    end
  end

  // Pipeline registers. Reset empties every stage, so any beats in flight
  // are discarded without producing output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      readyEn_q  <= 1'b0;
      s1Valid_q  <= 1'b0;
      s1Acc_q    <= '0;
      s1Scale_q  <= '0;
      s2Valid_q  <= 1'b0;
      s2Prod_q   <= '0;
      outValid_q <= 1'b0;
      q_q        <= '0;
      satCnt_q   <= '0;
    end else begin
      readyEn_q  <= 1'b1;
      s1Valid_q  <= s1Valid_d;
      s1Acc_q    <= s1Acc_d;
      s1Scale_q  <= s1Scale_d;
      s2Valid_q  <= s2Valid_d;
      s2Prod_q   <= s2Prod_d;
      outValid_q <= outValid_d;
      q_q        <= q_d;
      satCnt_q   <= satCnt_d;
    end
  end

  assign out_valid_o = outValid_q;
  assign q_o         = q_q;
  assign sat_cnt_o   = satCnt_q;

endmodule

// File: tb/tb_requant_pipe.sv
// ---------------------------------------------------------------------------
// tb_requant_pipe
//
// Directed testbench for requant_pipe. The DUT uses the default arithmetic
// parameters with a 48-entry scale table so that channel indices past the
// table end are reachable. Inputs are driven on the falling edge and outputs
// are sampled there as well, half a cycle away from the active edge.
// ---------------------------------------------------------------------------
module tb_requant_pipe;

  localparam int NUM_CH = 48;
  localparam int CH_W   = 6;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               in_valid_i;
  logic               in_ready_o;
  logic signed [23:0] acc_i;
  logic        [5:0]  ch_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic signed [7:0]  q_o;
  logic               cfg_we_i;
  logic        [5:0]  cfg_addr_i;
  logic        [15:0] cfg_scale_i;
  logic signed [7:0]  zero_point_i;
  logic               round_en_i;
  logic               relu_en_i;
  logic        [15:0] sat_cnt_o;
  logic               sat_clr_i;

  int errors = 0;
  int checks = 0;

  requant_pipe #(
    .ACC_W  (24),
    .SCALE_W(16),
    .SHIFT  (22),
    .NUM_CH (NUM_CH),
    .CNT_W  (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .acc_i       (acc_i),
    .ch_i        (ch_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .q_o         (q_o),
    .cfg_we_i    (cfg_we_i),
    .cfg_addr_i  (cfg_addr_i),
    .cfg_scale_i (cfg_scale_i),
    .zero_point_i(zero_point_i),
    .round_en_i  (round_en_i),
    .relu_en_i   (relu_en_i),
    .sat_cnt_o   (sat_cnt_o),
    .sat_clr_i   (sat_clr_i)
  );

  // 100 MHz free-running clock
  always #5 clk_i = ~clk_i;

  // Global time limit so a stuck DUT can never hang the run
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Sends one beat (optionally with a same-cycle table write and counter
  // clear) and waits a bounded number of cycles for its output. lat is the
  // number of falling edges after the drive edge at which out_valid_o was
  // first seen, or -1 if it never appeared.
  task automatic runBeat(input int acc, input int ch, input bit we,
                         input int addr, input int scale, input bit clr,
                         output logic [7:0] q, output int lat, output bit ok);
    bit found;
    @(negedge clk_i);
    in_valid_i  = 1'b1;
    acc_i       = 24'(acc);
    ch_i        = 6'(ch);
    out_ready_i = 1'b1;
    cfg_we_i    = we;
    cfg_addr_i  = 6'(addr);
    cfg_scale_i = 16'(scale);
    sat_clr_i   = clr;
    #1;
    ok    = in_ready_o;
    lat   = -1;
    q     = 8'h00;
    found = 1'b0;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    cfg_we_i   = 1'b0;
    for (int i = 1; i <= 8 && !found; i++) begin
      if (i > 1) @(negedge clk_i);
      if (out_valid_o === 1'b1) begin
        found = 1'b1;
        lat   = i;
        q     = q_o;
      end
    end
    sat_clr_i = 1'b0;
  endtask

  // Reset values and the input-ready release after reset
  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid_o); end
    checks++; if (q_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_q: got %0d expected 0", q_o); end
    checks++; if (sat_cnt_o !== 16'd0) begin errors++; $display("[TB] FAIL reset_sat_cnt: got %0d expected 0", sat_cnt_o); end
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready_o); end
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready: got %b expected 1", in_ready_o); end
  endtask

  // Default scale 2^15 with shift 22 is a factor of 1/128
  task automatic test_defaults();
    logic [7:0] q; int lat; bit ok;
    round_en_i = 1'b0;
    runBeat(1000, 0, 0, 0, 0, 0, q, lat, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL def_accept: got %b expected 1", ok); end
    checks++; if (lat != 3) begin errors++; $display("[TB] FAIL def_latency_floor_pos: got %0d expected 3", lat); end
    checks++; if (q !== 8'(7)) begin errors++; $display("[TB] FAIL def_floor_pos: got %0d expected 7", $signed(q)); end
    runBeat(-1000, 0, 0, 0, 0, 0, q, lat, ok);
    checks++; if (q !== 8'(-8)) begin errors++; $display("[TB] FAIL def_floor_neg: got %0d expected -8", $signed(q)); end
    round_en_i = 1'b1;
    runBeat(1000, 0, 0, 0, 0, 0, q, lat, ok);
    checks++; if (lat != 3) begin errors++; $display("[TB] FAIL def_latency_round_pos: got %0d expected 3", lat); end
    checks++; if (q !== 8'(8)) begin errors++; $display("[TB] FAIL def_round_pos: got %0d expected 8", $signed(q)); end
    runBeat(-1000, 0, 0, 0, 0, 0, q, lat, ok);
    checks++; if (q !== 8'(-8)) begin errors++; $display("[TB] FAIL def_round_neg: got %0d expected -8", $signed(q)); end
  endtask

  // Extreme accumulators saturate and are counted; clear beats increment
  task automatic test_saturation();
    logic [7:0] q; int lat; bit ok;
    round_en_i = 1'b1;
    checks++; if (sat_cnt_o !== 16'd0) begin errors++; $display("[TB] FAIL sat_start: got %0d expected 0", sat_cnt_o); end
    runBeat(8388607, 0, 0, 0, 0, 0, q, lat, ok);
    checks++; if (q !== 8'(127)) begin errors++; $display("[TB] FAIL sat_hi_q: got %0d expected 127", $signed(q)); end
    checks++; if (sat_cnt_o !== 16'd1) begin errors++; $display("[TB] FAIL sat_hi_cnt: got %0d expected 1", sat_cnt_o); end
    runBeat(-8388608, 0, 0, 0, 0, 0, q, lat, ok);
    checks++; if (q !== 8'(-128)) begin errors++; $display("[TB] FAIL sat_lo_q: got %0d expected -128", $signed(q)); end
    checks++; if (sat_cnt_o !== 16'd2) begin errors++; $display("[TB] FAIL sat_lo_cnt: got %0d expected 2", sat_cnt_o); end
    runBeat(1000, 0, 0, 0, 0, 0, q, lat, ok);
    checks++; if (sat_cnt_o !== 16'd2) begin errors++; $display("[TB] FAIL sat_no_event: got %0d expected 2", sat_cnt_o); end
    runBeat(8388607, 0, 0, 0, 0, 1, q, lat, ok);
    checks++; if (q !== 8'(127)) begin errors++; $display("[TB] FAIL sat_clr_q: got %0d expected 127", $signed(q)); end
    checks++; if (sat_cnt_o !== 16'd0) begin errors++; $display("[TB] FAIL sat_clr_priority: got %0d expected 0", sat_cnt_o); end
  endtask

  // Zero point shifts the result; ReLU clamps to it without counting
  task automatic test_zero_point();
    logic [7:0] q; int lat; bit ok;
    logic [15:0] cntBefore;
    zero_point_i = 8'sd10;
    round_en_i   = 1'b1;
    relu_en_i    = 1'b0;
    cntBefore    = sat_cnt_o;
    runBeat(1000, 0, 0, 0, 0, 0, q, lat, ok);
    checks++; if (q !== 8'(18)) begin errors++; $display("[TB] FAIL zp_pos: got %0d expected 18", $signed(q)); end
    runBeat(-5000, 0, 0, 0, 0, 0, q, lat, ok);
    checks++; if (q !== 8'(-29)) begin errors++; $display("[TB] FAIL zp_neg: got %0d expected -29", $signed(q)); end
    relu_en_i = 1'b1;
    runBeat(-5000, 0, 0, 0, 0, 0, q, lat, ok);
    checks++; if (q !== 8'(10)) begin errors++; $display("[TB] FAIL zp_relu: got %0d expected 10", $signed(q)); end
    runBeat(1000, 0, 0, 0, 0, 0, q, lat, ok);
    checks++; if (q !== 8'(18)) begin errors++; $display("[TB] FAIL zp_relu_pass: got %0d expected 18", $signed(q)); end
    checks++; if (sat_cnt_o !== cntBefore) begin errors++; $display("[TB] FAIL zp_relu_no_sat: got %0d expected %0d", sat_cnt_o, cntBefore); end
    zero_point_i = 8'sd0;
    relu_en_i    = 1'b0;
  endtask

  // Per-channel scales, write/read ordering and out-of-range channels
  task automatic test_scale_table();
    logic [7:0] q; int lat; bit ok;
    round_en_i = 1'b1;
    runBeat(1000, 5, 1, 5, 'h4000, 0, q, lat, ok);
    checks++; if (q !== 8'(8)) begin errors++; $display("[TB] FAIL scale_same_cycle: got %0d expected 8", $signed(q)); end
    runBeat(1000, 5, 0, 0, 0, 0, q, lat, ok);
    checks++; if (q !== 8'(4)) begin errors++; $display("[TB] FAIL scale_ch5: got %0d expected 4", $signed(q)); end
    runBeat(-1000, 5, 0, 0, 0, 0, q, lat, ok);
    checks++; if (q !== 8'(-4)) begin errors++; $display("[TB] FAIL scale_ch5_neg: got %0d expected -4", $signed(q)); end
    runBeat(1000, 6, 0, 0, 0, 0, q, lat, ok);
    checks++; if (q !== 8'(8)) begin errors++; $display("[TB] FAIL scale_ch6: got %0d expected 8", $signed(q)); end
    runBeat(1000, NUM_CH - 1, 0, 0, 0, 0, q, lat, ok);
    checks++; if (q !== 8'(8)) begin errors++; $display("[TB] FAIL scale_last_ch: got %0d expected 8", $signed(q)); end
    runBeat(1000, 50, 0, 0, 0, 0, q, lat, ok);
    checks++; if (q !== 8'(0)) begin errors++; $display("[TB] FAIL scale_out_of_range: got %0d expected 0", $signed(q)); end
  endtask

  // Eight beats under a fixed irregular out_ready pattern. The in-flight
  // count (sent minus received) tells when all three stages must be full.
  task automatic test_backpressure();
    logic [31:0] readyPat;
    int sent, recv;
    bit holding, expRdy;
    logic [7:0] heldQ;
    bit extra;
    readyPat   = 32'b1011_0010_0111_0001_1100_1010_0110_1001;
    sent       = 0;
    recv       = 0;
    holding    = 1'b0;
    heldQ      = 8'h00;
    round_en_i = 1'b0;
    for (int cyc = 0; cyc < 200 && recv < 8; cyc++) begin
      @(negedge clk_i);
      out_ready_i = readyPat[cyc % 32];
      in_valid_i  = (sent < 8);
      acc_i       = 24'(128 * (sent + 1));
      ch_i        = 6'd0;
      #1;
      if (holding) begin
        checks++; if (out_valid_o !== 1'b1 || q_o !== heldQ) begin errors++; $display("[TB] FAIL bp_stall_hold: got valid=%b q=%0d expected valid=1 q=%0d", out_valid_o, q_o, $signed(heldQ)); end
      end
      expRdy = !((sent - recv) == 3 && !out_ready_i);
      checks++; if (in_ready_o !== expRdy) begin errors++; $display("[TB] FAIL bp_in_ready: got %b expected %b at cycle %0d", in_ready_o, expRdy, cyc); end
      if (in_valid_i && in_ready_o) sent++;
      if (out_valid_o === 1'b1) begin
        if (out_ready_i) begin
          checks++; if (q_o !== 8'(recv + 1)) begin errors++; $display("[TB] FAIL bp_order: got %0d expected %0d", q_o, recv + 1); end
          recv++;
          holding = 1'b0;
        end else begin
          holding = 1'b1;
          heldQ   = q_o;
        end
      end
    end
    checks++; if (recv != 8) begin errors++; $display("[TB] FAIL bp_count: got %0d expected 8", recv); end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    extra       = 1'b0;
    repeat (5) begin
      @(negedge clk_i);
      if (out_valid_o !== 1'b0) extra = 1'b1;
    end
    checks++; if (extra !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_duplicate: got extra output expected none"); end
  endtask

  // Reset with three beats in flight discards them all
  task automatic test_reset_midstream();
    logic [7:0] q; int lat; bit ok;
    bit seen;
    round_en_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    acc_i       = 24'sd1000;
    ch_i        = 6'd0;
    repeat (3) @(negedge clk_i);
    in_valid_i = 1'b0;
    #1;
    checks++; if (out_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL mid_full_valid: got %b expected 1", out_valid_o); end
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_full_ready: got %b expected 0", in_ready_o); end
    rst_ni = 1'b0;
    #1;
    checks++; if (out_valid_o !== 1'b0 || q_o !== 8'h00) begin errors++; $display("[TB] FAIL mid_async_clear: got valid=%b q=%0d expected valid=0 q=0", out_valid_o, q_o); end
    @(negedge clk_i);
    rst_ni      = 1'b1;
    out_ready_i = 1'b1;
    seen        = 1'b0;
    repeat (8) begin
      @(negedge clk_i);
      if (out_valid_o !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_stale_output: got output expected none"); end
    runBeat(1000, 0, 0, 0, 0, 0, q, lat, ok);
    checks++; if (lat != 3 || q !== 8'(8)) begin errors++; $display("[TB] FAIL mid_recover: got lat=%0d q=%0d expected lat=3 q=8", lat, $signed(q)); end
  endtask

  // Test sequence
  initial begin
    in_valid_i   = 1'b0;
    acc_i        = '0;
    ch_i         = '0;
    out_ready_i  = 1'b1;
    cfg_we_i     = 1'b0;
    cfg_addr_i   = '0;
    cfg_scale_i  = '0;
    zero_point_i = '0;
    round_en_i   = 1'b0;
    relu_en_i    = 1'b0;
    sat_clr_i    = 1'b0;
    rst_ni       = 1'b1;
    #2 rst_ni    = 1'b0;

    test_reset();
    test_defaults();
    test_saturation();
    test_zero_point();
    test_scale_table();
    test_backpressure();
    test_reset_midstream();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/requant_pipe.md
REQUANT_PIPE -- requirements
Module: requant_pipe

Interface
REQ-001 Parameter ACC_W, 24, signed accumulator input width.
REQ-002 Parameter SCALE_W, 16, unsigned per-channel scale width.
REQ-003 Parameter SHIFT, 22, right-shift applied after the scale multiply; legal range 1..ACC_W+SCALE_W-1.
REQ-004 Parameter NUM_CH, 64, number of per-channel scale entries; CH_W = max(1, clog2(NUM_CH)).
REQ-005 Parameter CNT_W, 16, saturation counter width.
REQ-006 clk_i  in  1  single clock; all state on rising edge.
REQ-007 rst_ni  in  1  asynchronous active-low reset.
REQ-008 in_valid_i  in  1  input beat valid.
REQ-009 in_ready_o  out  1  block accepts the input beat this cycle.
REQ-010 acc_i  in  ACC_W  signed accumulator.
REQ-011 ch_i  in  CH_W  channel index; selects the scale entry.
REQ-012 out_valid_o  out  1  output beat valid.
REQ-013 out_ready_i  in  1  downstream accepts the output beat.
REQ-014 q_o  out  8  signed requantized result.
REQ-015 cfg_we_i  in  1  scale table write strobe.
REQ-016 cfg_addr_i  in  CH_W  scale table write address.
REQ-017 cfg_scale_i  in  SCALE_W  scale write data.
REQ-018 zero_point_i  in  8  signed output zero point; quasi-static.
REQ-019 round_en_i  in  1  1 = round half up; 0 = floor (truncate toward -inf); quasi-static.
REQ-020 relu_en_i  in  1  1 = lower clamp at zero_point_i; quasi-static.
REQ-021 sat_cnt_o  out  CNT_W  number of clamped results.
REQ-022 sat_clr_i  in  1  synchronous clear of sat_cnt_o.

Function
REQ-023 Three-stage pipeline: S1 registers acc and looks up the scale; S2 forms product = acc * unsigned scale (full ACC_W+SCALE_W+1-bit signed); S3 performs rounding, shift, zero point and clamp, registering q_o.
REQ-024 Latency: a beat accepted in cycle t appears on out_valid_o/q_o in cycle t+3 when out_ready_i is held high.
REQ-025 Throughput: one beat per cycle with no bubbles while out_ready_i=1.
REQ-026 Each stage holds a valid bit; a stage loads when it is empty or the next stage loads (the output stage unloads on out_valid_o & out_ready_i).
REQ-027 in_ready_o = S1 empty OR S1 advancing; it is combinational from out_ready_i and the stage valid bits only, never from in_valid_i.
REQ-028 While out_valid_o=1 and out_ready_i=0, q_o and out_valid_o hold stable.
REQ-029 Internal bubbles collapse: an empty stage loads even when the output is stalled.
REQ-030 Rounding: when round_en_i=1, add 2^(SHIFT-1) to the product before the arithmetic shift by SHIFT; when 0, shift only. No overflow occurs, because one guard bit is used.
REQ-031 Zero point: v = shifted + sign-extended zero_point_i, computed at full width.
REQ-032 Clamp: the lower bound is zero_point_i when relu_en_i=1, else -128; the upper bound is 127; q_o = v clamped to [lower, 127].
REQ-033 Saturation event: v > 127 or v < -128 on a beat leaving S3 into the output register. A ReLU clamp is not a saturation event.
REQ-034 sat_cnt_o increments by 1 per saturation event and sticks at 2^CNT_W-1.
REQ-035 sat_clr_i has priority over a same-cycle increment: the result is 0.
REQ-036 Scale table: NUM_CH x SCALE_W flops, written when cfg_we_i=1.
REQ-037 A write in cycle t affects beats accepted in cycle t+1 or later; a beat accepted in cycle t sees the old value, including for the same address.
REQ-038 An out-of-range ch_i or cfg_addr_i (at or above NUM_CH) reads as scale 0 and the write is ignored.
REQ-039 A scale of 0 yields v = zero_point_i, subject to the clamp.

Reset
REQ-040 Asynchronous reset clears all stage valid bits: out_valid_o=0, q_o=0, sat_cnt_o=0.
REQ-041 During reset in_ready_o=0; it asserts the first cycle after rst_ni deasserts.
REQ-042 Every scale table entry resets to 2^(SCALE_W-1), so the default factor is 2^(SCALE_W-1-SHIFT).
REQ-043 Reset mid-operation discards all in-flight beats, with no output produced for them.

Verification
REQ-044 Defaults after reset, zero_point=0, relu=0: acc=1000 gives q=7 with round=0 and q=8 with round=1; acc=-1000 gives q=-8 in both modes; each appears 3 cycles after acceptance.
REQ-045 Saturation: acc=8388607 gives q=127 and acc=-8388608 gives q=-128; sat_cnt_o goes 0->1->2; sat_clr_i=1 together with a saturating beat gives sat_cnt_o=0.
REQ-046 Zero point/ReLU: zp=10, round=1; acc=1000 gives q=18; acc=-5000 gives q=-29 with relu=0 and q=10 with relu=1, and sat_cnt_o is unchanged.
REQ-047 Per-channel scale: write ch 5 = 0x4000, then a beat acc=1000 on ch 5 gives q=4 (round=1) while ch 6 still gives 8; a write and a beat to ch 5 in the same cycle give 8.
REQ-048 Backpressure: stream 8 beats with out_ready_i toggling in a random pattern; the outputs must be in order, not duplicated, held stable while stalled, and in_ready_o must drop only when all 3 stages are full and stalled.
REQ-049 Reset mid-stream: assert rst_ni low with 3 beats in flight; no out_valid_o may occur afterwards until new beats are accepted.
